// File: rtl/apb_bus_bridge_pkg.sv
// Shared types for the CPU-to-APB bridge: FSM states, ramControl encodings
// and the access-legality rule.
package apb_bridge_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [2:0] RC_B  = 3'b000;
  localparam logic [2:0] RC_H  = 3'b001;
  localparam logic [2:0] RC_W  = 3'b010;
  localparam logic [2:0] RC_BU = 3'b100;
  localparam logic [2:0] RC_HU = 3'b101;

  // Unsigned widths only make sense for loads.
  function automatic logic rcLegal(input logic [2:0] rc, input logic we);
    case (rc)
      RC_B, RC_H, RC_W: return 1'b1;
      RC_BU, RC_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_bus_bridge_if.sv
// CPU load/store bus plus the APB side of the bridge in one bundle;
// master = the bridge, slave = the CPU and peripherals around it.
interface apb_bus_bridge_if #(
  parameter int NUM_SLAVES  = 4,
  parameter int REGION_BITS = 12
);
  logic                     busReq;
  logic                     busWe;
  logic [31:0]              busAddr;
  logic [31:0]              busWData;
  logic [2:0]               ramControl;
  logic [31:0]              busRData;
  logic                     busReady;
  logic                     busErr;

  logic [REGION_BITS-1:0]   PADDR;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [31:0]              PWDATA;
  logic [3:0]               PSTRB;
  logic [NUM_SLAVES*32-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;
  logic [NUM_SLAVES-1:0]    PSLVERR;

  modport master (
    input  busReq, busWe, busAddr, busWData, ramControl, PRDATA, PREADY, PSLVERR,
    output busRData, busReady, busErr, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output busReq, busWe, busAddr, busWData, ramControl, PRDATA, PREADY, PSLVERR,
    input  busRData, busReady, busErr, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_bus_bridge_lane_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely
// combinational, driven by the low address bits and funct3.
module bus_lane_align
  import apb_bridge_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [2:0]  rc,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [31:0] rdataExt,
  output logic        misalign
);
  logic [7:0]  rByte;
  logic [15:0] rHalf;

  assign rByte = 8'(rdata >> {addrLo, 3'b000});
  assign rHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];

  // rc[1:0] is the access size, rc[2] selects zero-extension.
  always_comb begin
    pwdata   = wdata;
    pstrb    = 4'b1111;
    rdataExt = rdata;
    misalign = 1'b0;
    case (rc[1:0])
      2'b00: begin
        pwdata   = {4{wdata[7:0]}};
        pstrb    = 4'b0001 << addrLo;
        rdataExt = rc[2] ? {24'b0, rByte} : {{24{rByte[7]}}, rByte};
      end
      2'b01: begin
        pwdata   = {2{wdata[15:0]}};
        pstrb    = 4'b0011 << addrLo;
        rdataExt = rc[2] ? {16'b0, rHalf} : {{16{rHalf[15]}}, rHalf};
        misalign = addrLo[0];
      end
      default: misalign = |addrLo;
    endcase
  end
endmodule

// File: rtl/apb_bus_bridge.sv
// CPU load/store to APB bridge: window decode, SETUP/ACCESS sequencing with
// wait-state timeout, and a one-cycle completion pulse back to the CPU.
module apb_bus_bridge
  import apb_bridge_pkg::*;
#(
  parameter int          NUM_SLAVES  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          REGION_BITS = 12,
  parameter int          TIMEOUT     = 255
) (
  input logic clk,
  input logic reset,
  apb_bus_bridge_if.master bus
);
  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int IW    = (SEL_W > 0) ? SEL_W : 1;
  localparam int HI    = REGION_BITS + SEL_W;

  state_t        state;
  logic [IW-1:0] idxQ, idxIn;
  logic [1:0]    addrLoQ;
  logic [2:0]    rcQ;
  logic          weQ;
  logic [15:0]   waitCnt;

  logic [31:0]   prSel;
  logic          rdySel, errSel;
  logic          hit, legal;
  logic [1:0]    alnAddr;
  logic [2:0]    alnRc;
  logic [31:0]   alnWData, alnRData;
  logic [3:0]    alnStrb;
  logic          alnMis;

  assign hit   = (bus.busAddr >> HI) == (BASE_ADDR >> HI);
  assign idxIn = (SEL_W == 0) ? '0 : IW'(bus.busAddr >> REGION_BITS);
  assign legal = hit && (int'(idxIn) < NUM_SLAVES) &&
                 rcLegal(bus.ramControl, bus.busWe) && !alnMis;

  // Live request bits drive the aligner while decoding, latched ones afterwards.
  assign alnAddr = (state == IDLE) ? bus.busAddr[1:0] : addrLoQ;
  assign alnRc   = (state == IDLE) ? bus.ramControl   : rcQ;

  bus_lane_align uAlign (
    .addrLo   (alnAddr),
    .rc       (alnRc),
    .wdata    (bus.busWData),
    .rdata    (prSel),
    .pwdata   (alnWData),
    .pstrb    (alnStrb),
    .rdataExt (alnRData),
    .misalign (alnMis)
  );

  always_comb begin
    prSel  = '0;
    rdySel = 1'b0;
    errSel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idxQ == IW'(i)) begin
        prSel  = bus.PRDATA[32*i +: 32];
        rdySel = bus.PREADY[i];
        errSel = bus.PSLVERR[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idxQ         <= '0;
      addrLoQ      <= '0;
      rcQ          <= '0;
      weQ          <= 1'b0;
      waitCnt      <= '0;
      bus.busRData <= '0;
      bus.busReady <= 1'b0;
      bus.busErr   <= 1'b0;
      bus.PADDR    <= '0;
      bus.PSEL     <= '0;
      bus.PENABLE  <= 1'b0;
      bus.PWRITE   <= 1'b0;
      bus.PWDATA   <= '0;
      bus.PSTRB    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.busReq) begin
          idxQ    <= idxIn;
          addrLoQ <= bus.busAddr[1:0];
          rcQ     <= bus.ramControl;
          weQ     <= bus.busWe;
          waitCnt <= '0;
          if (legal) begin
            state      <= SETUP;
            bus.PSEL   <= NUM_SLAVES'(1) << idxIn;
            bus.PADDR  <= {bus.busAddr[REGION_BITS-1:2], 2'b00};
            bus.PWRITE <= bus.busWe;
            bus.PWDATA <= bus.busWe ? alnWData : '0;
            bus.PSTRB  <= bus.busWe ? alnStrb  : '0;
          end else begin
            state        <= RESP;
            bus.busReady <= 1'b1;
            bus.busErr   <= 1'b1;
            bus.busRData <= '0;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        // waitCnt counts ACCESS cycles already spent without PREADY.
        ACCESS: if (rdySel || waitCnt == 16'(TIMEOUT)) begin
          state        <= RESP;
          bus.busReady <= 1'b1;
          bus.busErr   <= !rdySel || errSel;
          bus.busRData <= (rdySel && !errSel && !weQ) ? alnRData : '0;
          bus.PSEL     <= '0;
          bus.PENABLE  <= 1'b0;
          bus.PADDR    <= '0;
          bus.PWRITE   <= 1'b0;
          bus.PWDATA   <= '0;
          bus.PSTRB    <= '0;
        end else begin
          waitCnt <= waitCnt + 16'd1;
        end
        RESP: begin
          state        <= IDLE;
          bus.busReady <= 1'b0;
          bus.busErr   <= 1'b0;
          bus.busRData <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_bus_bridge.sv
// Directed bench for apb_bus_bridge: a transaction-level model predicts every
// output cycle by cycle, plus literal checks on the notable transactions.
module tb_apb_bus_bridge;
  localparam int          NS   = 4;
  localparam int          RB   = 12;
  localparam int          TMO  = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  apb_bus_bridge_if #(.NUM_SLAVES(NS), .REGION_BITS(RB)) bus ();

  apb_bus_bridge #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .REGION_BITS(RB), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit active = 1'b0;
  int edgeCnt = 0;
  int expLat;
  bit expSelOn, expErr, expWe;
  logic [31:0]   expRData, expPwdata;
  logic [3:0]    expPstrb, expSel;
  logic [RB-1:0] expPaddr;

  int seenLat;
  bit seenErr;
  logic [31:0]   seenRData, seenPwdata;
  logic [3:0]    seenPsel, seenPstrb, seenSelOr;
  logic [RB-1:0] seenPaddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic anyOut();
    return |{bus.busRData, bus.busReady, bus.busErr, bus.PADDR, bus.PSEL,
             bus.PENABLE, bus.PWRITE, bus.PWDATA, bus.PSTRB};
  endfunction

  // Cycle-by-cycle compare; e = cycles since the request was sampled.
  initial begin : cmp
    int e;
    bit inApb;
    forever begin
      @(posedge clk);
      #2;
      if (!active) begin
        chk("idle_zero", 32'(anyOut()), 32'd0);
      end else begin
        edgeCnt++;
        e = edgeCnt;
        inApb = expSelOn && e >= 1 && e < expLat;
        chk("busReady", 32'(bus.busReady), 32'(e == expLat));
        chk("busErr", 32'(bus.busErr), 32'(e == expLat && expErr));
        chk("PSEL", 32'(bus.PSEL), inApb ? 32'(expSel) : 32'd0);
        chk("PENABLE", 32'(bus.PENABLE), 32'(inApb && e >= 2));
        if (inApb) begin
          chk("PADDR", 32'(bus.PADDR), 32'(expPaddr));
          chk("PWRITE", 32'(bus.PWRITE), 32'(expWe));
          chk("PSTRB", 32'(bus.PSTRB), 32'(expPstrb));
          if (expWe) chk("PWDATA", bus.PWDATA, expPwdata);
        end
        seenSelOr = seenSelOr | bus.PSEL;
        if (bus.PSEL != '0) begin
          seenPsel   = bus.PSEL;
          seenPaddr  = bus.PADDR;
          seenPstrb  = bus.PSTRB;
          seenPwdata = bus.PWDATA;
        end
        if (bus.busReady) begin
          seenLat   = e;
          seenErr   = bus.busErr;
          seenRData = bus.busRData;
        end
        if (e == expLat) begin
          if (!expWe || expErr) chk("busRData", bus.busRData, expRData);
          active = 1'b0;
        end
      end
    end
  end

  // One CPU request; k = ACCESS wait cycles before the target slave is ready.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] rc, input int k, input logic [31:0] prd,
                     input bit slverr, input int abortAt);
    int idx, size, sh;
    bit hit, okRc, ok;
    logic [31:0] v, mask;
    hit  = addr >= BASE && addr < BASE + 32'(NS << RB);
    idx  = hit ? int'((addr - BASE) >> RB) : 0;
    okRc = (rc inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && !(we && rc[2]);
    size = (rc[1:0] == 2'b00) ? 1 : (rc[1:0] == 2'b01) ? 2 : 4;
    sh   = int'(addr[1:0]);
    ok   = hit && okRc && (sh % size == 0);

    expWe    = we;
    expSelOn = ok;
    expSel   = 4'(1 << idx);
    expPaddr = RB'(((addr - BASE) >> 2) << 2);
    expPstrb = we ? 4'(((1 << size) - 1) << sh) : 4'd0;
    for (int j = 0; j < 4; j++) expPwdata[8*j +: 8] = wdata[8*(j % size) +: 8];
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*size)) - 32'd1;
    v = (prd >> (8*sh)) & mask;
    if (!rc[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    if (!ok)          begin expLat = 1;       expErr = 1'b1;   end
    else if (k > TMO) begin expLat = 3 + TMO; expErr = 1'b1;   end
    else              begin expLat = 3 + k;   expErr = slverr; end
    expRData = expErr ? 32'd0 : v;

    seenLat = 0; seenErr = 1'b0; seenRData = 32'hBAD0_BAD0;
    seenPsel = '0; seenSelOr = '0; seenPstrb = '0; seenPwdata = '0; seenPaddr = '0;
    bus.busReq = 1'b1; bus.busWe = we; bus.busAddr = addr;
    bus.busWData = wdata; bus.ramControl = rc;
    edgeCnt = 0;
    active = 1'b1;
    while (active) begin
      // Non-target slaves look ready and erroring so any leak shows up.
      for (int s = 0; s < NS; s++) begin
        bus.PREADY[s]          = (hit && s == idx) ? (edgeCnt == 2 + k) : 1'b1;
        bus.PSLVERR[s]         = (hit && s == idx) ? slverr : 1'b1;
        bus.PRDATA[32*s +: 32] = (hit && s == idx) ? prd : $urandom;
      end
      @(negedge clk);
      if (abortAt > 0 && edgeCnt == abortAt && active) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_zero", 32'(anyOut()), 32'd0);
        active = 1'b0;
      end
    end
    bus.busReq = 1'b0; bus.busWe = 1'b0; bus.busAddr = '0;
    bus.busWData = '0; bus.ramControl = '0;
    if (abortAt > 0) begin
      repeat (2) @(negedge clk);
      reset = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.busReq = 1'b0; bus.busWe = 1'b0; bus.busAddr = '0; bus.busWData = '0;
    bus.ramControl = '0; bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
    repeat (3) @(negedge clk);
    chk("reset_zero", 32'(anyOut()), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    txn(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 3'b010, 0, 32'd0, 1'b0, 0);
    chk("sw_psel", 32'(seenPsel), 32'h2);
    chk("sw_paddr", 32'(seenPaddr), 32'h004);
    chk("sw_pstrb", 32'(seenPstrb), 32'hF);
    chk("sw_pwdata", seenPwdata, 32'hDEAD_BEEF);
    chk("sw_lat", 32'(seenLat), 32'd3);
    chk("sw_err", 32'(seenErr), 32'd0);

    txn(1'b0, 32'h1000_0003, 32'd0, 3'b000, 3, 32'h8012_3456, 1'b0, 0);
    chk("lb_rdata", seenRData, 32'hFFFF_FF80);
    chk("lb_lat", 32'(seenLat), 32'd6);
    txn(1'b0, 32'h1000_0003, 32'd0, 3'b100, 3, 32'h8012_3456, 1'b0, 0);
    chk("lbu_rdata", seenRData, 32'h0000_0080);

    txn(1'b1, 32'h1000_2002, 32'h0000_1234, 3'b001, 0, 32'd0, 1'b0, 0);
    chk("sh_pwdata", seenPwdata, 32'h1234_1234);
    chk("sh_pstrb", 32'(seenPstrb), 32'hC);
    chk("sh_psel", 32'(seenPsel), 32'h4);

    txn(1'b1, 32'h1000_0001, 32'hFFFF_FFA5, 3'b000, 1, 32'd0, 1'b0, 0);
    chk("sb_pwdata", seenPwdata, 32'hA5A5_A5A5);
    chk("sb_pstrb", 32'(seenPstrb), 32'h2);

    txn(1'b0, 32'h1000_2001, 32'd0, 3'b010, 0, 32'h1111_1111, 1'b0, 0);
    chk("lwmis_lat", 32'(seenLat), 32'd1);
    chk("lwmis_err", 32'(seenErr), 32'd1);
    chk("lwmis_rdata", seenRData, 32'd0);
    chk("lwmis_psel", 32'(seenSelOr), 32'd0);
    txn(1'b0, 32'h1000_0000, 32'd0, 3'b011, 0, 32'h1111_1111, 1'b0, 0);
    chk("rc011_lat", 32'(seenLat), 32'd1);
    chk("rc011_psel", 32'(seenSelOr), 32'd0);
    txn(1'b0, 32'h2000_0000, 32'd0, 3'b010, 0, 32'h1111_1111, 1'b0, 0);
    chk("miss_err", 32'(seenErr), 32'd1);
    chk("miss_psel", 32'(seenSelOr), 32'd0);
    txn(1'b1, 32'h1000_0000, 32'h55, 3'b100, 0, 32'd0, 1'b0, 0);
    chk("sbu_err", 32'(seenErr), 32'd1);
    txn(1'b0, 32'h1000_4000, 32'd0, 3'b010, 0, 32'h1111_1111, 1'b0, 0);
    chk("above_err", 32'(seenErr), 32'd1);

    txn(1'b0, 32'h1000_2000, 32'd0, 3'b010, 100, 32'h1234_5678, 1'b0, 0);
    chk("tmo_lat", 32'(seenLat), 32'd11);
    chk("tmo_err", 32'(seenErr), 32'd1);
    chk("tmo_rdata", seenRData, 32'd0);

    txn(1'b0, 32'h1000_3008, 32'd0, 3'b010, 1, 32'h1122_3344, 1'b1, 0);
    chk("slverr_err", 32'(seenErr), 32'd1);
    chk("slverr_rdata", seenRData, 32'd0);

    txn(1'b0, 32'h1000_3002, 32'd0, 3'b001, 2, 32'h8001_7FFF, 1'b0, 0);
    chk("lh_rdata", seenRData, 32'hFFFF_8001);
    txn(1'b0, 32'h1000_3002, 32'd0, 3'b101, 0, 32'h8001_7FFF, 1'b0, 0);
    chk("lhu_rdata", seenRData, 32'h0000_8001);
    txn(1'b0, 32'h1000_3000, 32'd0, 3'b001, 0, 32'h8001_7FFF, 1'b0, 0);
    chk("lh_lo_rdata", seenRData, 32'h0000_7FFF);
    txn(1'b0, 32'h1000_3001, 32'd0, 3'b000, 0, 32'h8001_7FFF, 1'b0, 0);
    chk("lb_b1_rdata", seenRData, 32'h0000_007F);

    txn(1'b0, 32'h1000_1000, 32'd0, 3'b010, 5, 32'h7777_7777, 1'b0, 3);
    chk("abort_ready", 32'(seenLat), 32'd0);
    txn(1'b0, 32'h1000_1010, 32'd0, 3'b010, 2, 32'hCAFE_F00D, 1'b0, 0);
    chk("post_rst_rdata", seenRData, 32'hCAFE_F00D);
    chk("post_rst_lat", 32'(seenLat), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
